// File: rtl/field_pack_arbiter.sv
// field_pack_arbiter: round-robin arbiter that packs granted requester fields
// MSB-first into one output word, delivered on a valid/ready interface.
//
// Handshake: out_valid is high only in HOLD, where out_data/out_fields stay
// frozen. A word transfers on a rising clk edge where out_valid && out_ready.
// The accepting edge returns to FILL, so the cycle after it is a bubble.
// gnt is combinational, and the granted field is captured on the same edge.
module field_pack_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int FIELD_W = 2,
    parameter int FIELDS  = 4,
    parameter logic [FIELD_W-1:0] PAD_FIELD = 2'b10,
    localparam int OUT_W = FIELD_W * FIELDS,
    localparam int CNT_W = $clog2(FIELDS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*FIELD_W-1:0] field_in,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [CNT_W-1:0]           out_fields
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   fill_cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic               grant_any;
    logic [PTR_W-1:0]   win_idx;
    logic [FIELD_W-1:0] win_field;
    logic               pad_now;
    logic               last_slot;
    int                 idx;

    // Flush closes a non-empty partial word and beats any request that cycle.
    assign pad_now   = rst_n && (state_q == FILL) && flush && (fill_cnt != '0);
    assign last_slot = (fill_cnt == CNT_W'(FIELDS - 1));
    assign win_field = field_in[win_idx*FIELD_W +: FIELD_W];
    assign out_valid = (state_q == HOLD);

    // Round-robin search starting at rr_ptr; gated off in reset, HOLD and pad cycles.
    always_comb begin
        gnt       = '0;
        grant_any = 1'b0;
        win_idx   = '0;
        idx       = 0;
        if (rst_n && (state_q == FILL) && !pad_now) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!grant_any && req[idx]) begin
                    grant_any = 1'b1;
                    win_idx   = PTR_W'(idx);
                end
            end
        end
        if (grant_any) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Next-state: FILL -> HOLD on last slot or pad, HOLD -> FILL on accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (pad_now || (grant_any && last_slot)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: slot capture, padding, fill counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt   <= '0;
            rr_ptr     <= '0;
            out_data   <= '0;
            out_fields <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (pad_now) begin
                        for (int s = 0; s < FIELDS; s++) begin
                            if (s >= int'(fill_cnt)) begin
                                out_data[OUT_W-1-FIELD_W*s -: FIELD_W] <= PAD_FIELD;
                            end
                        end
                        out_fields <= fill_cnt;
                    end else if (grant_any) begin
                        for (int s = 0; s < FIELDS; s++) begin
                            if (s == int'(fill_cnt)) begin
                                out_data[OUT_W-1-FIELD_W*s -: FIELD_W] <= win_field;
                            end
                        end
                        fill_cnt <= fill_cnt + CNT_W'(1);
                        rr_ptr   <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
                        if (last_slot) begin
                            out_fields <= CNT_W'(FIELDS);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        fill_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_in_hold : assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> (gnt == '0));
    a_fields_max  : assert property (@(posedge clk) disable iff (!rst_n) int'(out_fields) <= FIELDS);

endmodule
